// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: command-latched LED driver with static, blink, shift and PWM modes.
// Build option: define LED_ACTIVE_LOW_EN for inverted (active-low) LED drive.
module led_pattern_ctrl #(
   parameter int LED_WIDTH      = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int CALLBACK_WIDTH = 16,
   parameter int STEP_CYCLES    = 12_500_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic                      clr_i,
   input  logic [DATA_WIDTH-1:0]     data_in_w,
   output logic [CALLBACK_WIDTH-1:0] callback_o,
   output logic [LED_WIDTH-1:0]      led_o
);

   localparam int LW = LED_WIDTH;
   localparam int SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

   localparam logic [1:0] M_STATIC = 2'b00;
   localparam logic [1:0] M_BLINK  = 2'b01;
   localparam logic [1:0] M_SHIFT  = 2'b10;
   localparam logic [1:0] M_PWM    = 2'b11;

   typedef enum logic [1:0] {
      CLEAR = 2'b00,
      LOAD  = 2'b01,
      RUN   = 2'b10,
      BAD   = 2'b11
   } state_t;

   state_t                    state;
   logic                      en_r;
   logic                      en_q;
   logic                      clr_r;
   logic                      load_w;
   logic                      step_w;
   logic [LW-1:0]             led_r;
   logic [LW-1:0]             pattern;
   logic [7:0]                duty;
   logic [1:0]                mode;
   logic [SW-1:0]             step_cnt;
   logic [7:0]                pwm_cnt;
   logic [7:0]                pwm_nxt;
   logic                      blink_off;
   logic [CALLBACK_WIDTH-1:0] cb_r;

   logic [LW-1:0]             new_pattern;
   logic [7:0]                new_duty;
   logic [1:0]                new_mode;

   assign new_pattern = data_in_w[LW-1:0];
   assign new_duty    = data_in_w[LW+7:LW];
   assign new_mode    = data_in_w[LW+9:LW+8];

   generate
      if (DATA_WIDTH > LW + 10) begin : g_spare
         logic unused_data;
         assign unused_data = ^data_in_w[DATA_WIDTH-1:LW+10];
      end
   endgenerate

   assign load_w  = en_r & ~en_q;
   assign step_w  = (step_cnt == STEP_LAST);
   assign pwm_nxt = pwm_cnt + 8'd1;

   // Register the strobes; the two-stage en pipe yields a one-shot load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_r  <= 1'b0;
         en_q  <= 1'b0;
         clr_r <= 1'b0;
      end else begin
         en_r  <= en_i;
         en_q  <= en_r;
         clr_r <= clr_i;
      end
   end

   // Control FSM: command latch plus per-mode animation of led_r.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR;
         led_r     <= '0;
         pattern   <= '0;
         duty      <= '0;
         mode      <= '0;
         step_cnt  <= '0;
         pwm_cnt   <= '0;
         blink_off <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               led_r     <= '0;
               step_cnt  <= '0;
               pwm_cnt   <= '0;
               blink_off <= 1'b0;
               if (load_w && !clr_r)
                  state <= LOAD;
            end
            LOAD: begin
               pattern   <= new_pattern;
               duty      <= new_duty;
               mode      <= new_mode;
               step_cnt  <= '0;
               pwm_cnt   <= '0;
               blink_off <= 1'b0;
               if (new_mode == M_PWM)
                  led_r <= new_pattern & {LW{|new_duty}};
               else
                  led_r <= new_pattern;
               state <= RUN;
            end
            RUN: begin
               if (clr_r) begin
                  state <= CLEAR;
                  led_r <= '0;
               end else if (load_w) begin
                  state <= LOAD;
               end else begin
                  step_cnt <= step_w ? '0 : step_cnt + SW'(1);
                  pwm_cnt  <= pwm_nxt;
                  unique case (mode)
                     M_STATIC: led_r <= pattern;
                     M_BLINK: begin
                        if (step_w) begin
                           blink_off <= ~blink_off;
                           led_r     <= blink_off ? pattern : '0;
                        end
                     end
                     M_SHIFT: begin
                        if (step_w)
                           led_r <= {led_r[LW-2:0], led_r[LW-1]};
                     end
                     M_PWM: led_r <= pattern & {LW{pwm_nxt < duty}};
                  endcase
               end
            end
            BAD: begin
               state <= CLEAR;
               led_r <= '0;
            end
         endcase
      end
   end

   // Status readback, one cycle behind the live registers.
   always_ff @(posedge clk) begin
      if (!rst_n || state == BAD)
         cb_r <= '0;
      else
         cb_r <= CALLBACK_WIDTH'({state, mode, led_r});
   end

   assign callback_o = cb_r;

`ifdef LED_ACTIVE_LOW_EN
   assign led_o = ~led_r;
`else
   assign led_o = led_r;
`endif

endmodule
